ram_rr_arbiter: RTL
===================

// Module: ram_rr_arbiter
// PURPOSE
//  Shares one simple dual-port RAM (param_ram, instantiated inside) between NUM_REQ requesters.
//  Independent round-robin arbitration on the write port and on the read port.
//  Read data returns one cycle after acceptance, steered to the winner by a one-hot valid.
//  Sits between client engines and their common parameter/table storage.
// PARAMETERS
//  NUM_REQ     4    number of requesters (>=2)
//  WIDTH_DATA  32   RAM word width
//  NUMWORDS    256  RAM depth; AW = $clog2(NUMWORDS)
// PORTS
//  clk           in   1               single clock, rising edge
//  rst_n         in   1               asynchronous, active-low reset
//  wr_req_valid  in   NUM_REQ         per-requester write request
//  wr_req_ready  out  NUM_REQ         write grant; at most one bit set
//  wr_req_addr   in   NUM_REQ x AW    write address per requester
//  wr_req_data   in   NUM_REQ x WIDTH_DATA  write data per requester
//  rd_req_valid  in   NUM_REQ         per-requester read request
//  rd_req_ready  out  NUM_REQ         read grant; at most one bit set
//  rd_req_addr   in   NUM_REQ x AW    read address per requester
//  rd_rsp_valid  out  NUM_REQ         one-hot read response strobe
//  rd_rsp_data   out  WIDTH_DATA      read data, shared by all requesters
// BEHAVIOUR
//  - Transfer occurs when valid[i] && ready[i]. ready is combinational from valid and the pointer.
//  - Requester holds valid/addr/data stable until accepted.
//  - Round robin, one arbiter per port:
//    - Pointer p (reset 0); search order p, p+1, ... wrapping mod NUM_REQ.
//    - First valid index wins; on a grant to index g, p <= (g+1) mod NUM_REQ.
//    - No grant: p holds.
//  - Write accepted in cycle T: mem[addr] updated at edge ending T.
//  - Read accepted in cycle T: rd_rsp_valid[g]=1 for exactly cycle T+1 with rd_rsp_data.
//    - Latency 1; no response backpressure; requester must sink it.
//  - Read and write ports are fully concurrent; a requester may win both in one cycle.
//  - Same-cycle write and read to one address: see CONFIGURATION.
//  - Back-to-back reads: one per cycle; responses come in grant order.
//  - While rst_n low: p=0 (both ports), rd_rsp_valid=0, wr_req_ready=0, rd_req_ready=0.
//    - rd_rsp_data is not reset (X until the first response); qualify it with rd_rsp_valid.
//  - Reset mid-operation:
//    - A read accepted in the cycle before reset produces no response.
//    - RAM contents are not cleared; a write is retained only if its edge preceded rst_n falling.
// CONFIGURATION
//  RAM_ARB_BYPASS_EN defined:
//    - Same-cycle write+read to an equal address returns the new write data.
//    - Registered address-compare flag and data select this.
//  RAM_ARB_BYPASS_EN undefined:
//    - Same-cycle collision returns the old RAM contents (read-before-write).
//    - No compare logic.
// STRUCTURE
//  - ram_arb_pkg:
//    - DEF_NUM_REQ, DEF_WIDTH_DATA, DEF_NUMWORDS defaults.
//    - Function onehot_to_idx() for grant encoding.
//  - Sub-module rr_arbiter #(N): valid vector in, one-hot grant out, owns pointer. Instantiated twice.
//  - Top level holds the address/data muxes, the 1-deep read-tag register and the param_ram instance.
// TESTING
//  1. Reset, then req1 write addr 5 = 0xA5A5, then req1 read addr 5
//     -> rd_rsp_valid=4'b0010 one cycle later, data 0xA5A5.
//  2. All four rd_req_valid held high for 8 cycles
//     -> grants 0,1,2,3,0,1,2,3; responses one-hot in the same order, each at +1.
//  3. Only req2 and req3 valid, pointer at 0
//     -> grants 2,3,2,3; req0/req1 ready stay 0.
//  4. Write addr 9=0x1111 then, in the same cycle, write addr 9=0x2222 and read addr 9
//     -> 0x2222 with RAM_ARB_BYPASS_EN, 0x1111 without.
//  5. Read accepted, then rst_n low the next cycle
//     -> no rd_rsp_valid; after release grants restart at req0.
//  6. req0 write and req3 read in the same cycle to different addresses
//     -> both accepted; read data is the prior contents.

Source files
------------

// File: rtl/ram_rr_arbiter_pkg.sv
// Shared defaults and grant-encoding helper for the RAM round-robin arbiter.
// Optional same-cycle write-to-read forwarding is enabled by RAM_ARB_BYPASS_EN.
package ram_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_WIDTH_DATA = 32;
    localparam int DEF_NUMWORDS   = 256;
    localparam int MAX_REQ        = 32;

    function automatic int unsigned onehot_to_idx(
        input logic [MAX_REQ-1:0] oh
    );
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/ram_rr_arbiter_if.sv
// Requester-side bundle of the shared RAM: write port, read port, read response.
// master = requesters, slave = arbiter.
interface ram_rr_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int WIDTH_DATA = DEF_WIDTH_DATA,
    parameter int AW         = $clog2(DEF_NUMWORDS)
);
    logic [NUM_REQ-1:0]                 wr_req_valid;
    logic [NUM_REQ-1:0]                 wr_req_ready;
    logic [NUM_REQ-1:0][AW-1:0]         wr_req_addr;
    logic [NUM_REQ-1:0][WIDTH_DATA-1:0] wr_req_data;
    logic [NUM_REQ-1:0]                 rd_req_valid;
    logic [NUM_REQ-1:0]                 rd_req_ready;
    logic [NUM_REQ-1:0][AW-1:0]         rd_req_addr;
    logic [NUM_REQ-1:0]                 rd_rsp_valid;
    logic [WIDTH_DATA-1:0]              rd_rsp_data;

    modport master (
        output wr_req_valid, wr_req_addr, wr_req_data,
        output rd_req_valid, rd_req_addr,
        input  wr_req_ready, rd_req_ready,
        input  rd_rsp_valid, rd_rsp_data
    );

    modport slave (
        input  wr_req_valid, wr_req_addr, wr_req_data,
        input  rd_req_valid, rd_req_addr,
        output wr_req_ready, rd_req_ready,
        output rd_rsp_valid, rd_rsp_data
    );

endinterface

// File: rtl/ram_rr_arbiter_ram.sv
// Simple dual-port RAM, one write and one registered read per cycle.
// A same-address read sees the contents from before the write.
module param_ram #(
    parameter int WIDTH_DATA = 32,
    parameter int NUMWORDS   = 256,
    parameter int AW         = $clog2(NUMWORDS)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [WIDTH_DATA-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [WIDTH_DATA-1:0] o_rd_data
);
    logic [WIDTH_DATA-1:0] r_mem [NUMWORDS];
    logic [WIDTH_DATA-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ram_rr_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward with wrap,
// and moves the pointer just past the winner.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_valid,
    output logic [N-1:0] o_grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;
    logic [N-1:0]  w_gnt;
    logic          w_found;
    int            w_g;

    // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        w_gnt   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_valid[i] && i >= int'(r_ptr)) begin
                w_gnt[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_valid[i] && i < int'(r_ptr)) begin
                w_gnt[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

    assign o_grant = w_gnt & {N{rst_n}};

    always_comb begin
        w_g = int'(onehot_to_idx(MAX_REQ'(o_grant)));
        if (w_g >= N - 1) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = PW'(w_g + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (|o_grant) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Shares one dual-port RAM between NUM_REQ requesters with per-port round robin.
// Define RAM_ARB_BYPASS_EN to forward same-cycle write data to a colliding read.
module ram_rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int WIDTH_DATA = DEF_WIDTH_DATA,
    parameter int NUMWORDS   = DEF_NUMWORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    ram_rr_arbiter_if.slave  bus
);
    localparam int AW = $clog2(NUMWORDS);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    w_wr_gnt;
    logic [NUM_REQ-1:0]    w_rd_gnt;
    logic [PW-1:0]         w_wr_idx;
    logic [PW-1:0]         w_rd_idx;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [AW-1:0]         w_wr_addr;
    logic [AW-1:0]         w_rd_addr;
    logic [WIDTH_DATA-1:0] w_wr_data;
    logic [WIDTH_DATA-1:0] w_ram_q;
    logic [NUM_REQ-1:0]    r_rsp_valid;

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (bus.wr_req_valid),
        .o_grant (w_wr_gnt)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (bus.rd_req_valid),
        .o_grant (w_rd_gnt)
    );

    assign w_wr_idx  = PW'(onehot_to_idx(MAX_REQ'(w_wr_gnt)));
    assign w_rd_idx  = PW'(onehot_to_idx(MAX_REQ'(w_rd_gnt)));
    assign w_wr_en   = |w_wr_gnt;
    assign w_rd_en   = |w_rd_gnt;
    assign w_wr_addr = bus.wr_req_addr[w_wr_idx];
    assign w_wr_data = bus.wr_req_data[w_wr_idx];
    assign w_rd_addr = bus.rd_req_addr[w_rd_idx];

    assign bus.wr_req_ready = w_wr_gnt;
    assign bus.rd_req_ready = w_rd_gnt;

    // Read tag: which requester owns the data coming out next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
        end else begin
            r_rsp_valid <= w_rd_gnt;
        end
    end

    assign bus.rd_rsp_valid = r_rsp_valid;

    param_ram #(
        .WIDTH_DATA (WIDTH_DATA),
        .NUMWORDS   (NUMWORDS),
        .AW         (AW)
    ) u_ram (
        .clk        (clk),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (w_wr_addr),
        .i_wr_data  (w_wr_data),
        .i_rd_en    (w_rd_en),
        .i_rd_addr  (w_rd_addr),
        .o_rd_data  (w_ram_q)
    );

`ifdef RAM_ARB_BYPASS_EN
    logic                  r_byp;
    logic [WIDTH_DATA-1:0] r_byp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byp <= 1'b0;
        end else begin
            r_byp <= w_wr_en && w_rd_en && (w_wr_addr == w_rd_addr);
        end
    end

    always_ff @(posedge clk) begin
        r_byp_data <= w_wr_data;
    end

    assign bus.rd_rsp_data = r_byp ? r_byp_data : w_ram_q;
`else
    assign bus.rd_rsp_data = w_ram_q;
`endif

endmodule
